// File: rtl/counter_share_pkg.sv
// Shared constants and helpers for the counter_share_arbiter slice.
package counter_share_pkg;

  localparam int unsigned N_DEF     = 36;
  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned IDX_W_DEF = $clog2(NREQ_DEF);
  localparam int unsigned MAX_NREQ  = 32;

  // Callers truncate the result to their own channel count.
  function automatic logic [MAX_NREQ-1:0] onehot(input int unsigned idx);
    return {{(MAX_NREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/counter_share_arbiter_rr.sv
// Combinational round-robin selector: first eligible index at or after ptr, wrapping.
module rr_arbiter
  import counter_share_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]         elig,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic                    sel_valid,
  output logic [$clog2(NREQ)-1:0] sel_idx
);

  localparam int unsigned IW = $clog2(NREQ);

  logic          hi_valid;
  logic          lo_valid;
  logic [IW-1:0] hi_idx;
  logic [IW-1:0] lo_idx;

  // Two priority passes: indices >= ptr first, then the lowest index overall.
  always_comb begin
    hi_valid = 1'b0;
    lo_valid = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!hi_valid && elig[i] && (IW'(i) >= ptr)) begin
        hi_valid = 1'b1;
        hi_idx   = IW'(i);
      end
      if (!lo_valid && elig[i]) begin
        lo_valid = 1'b1;
        lo_idx   = IW'(i);
      end
    end
    sel_valid = hi_valid | lo_valid;
    sel_idx   = hi_valid ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/counter_share_arbiter.sv
// NREQ up-counters sharing one incrementer under round-robin arbitration.
// Optional COUNTER_SHARE_SATURATE_EN: saturate at all-ones instead of wrapping.
module counter_share_arbiter
  import counter_share_pkg::*;
#(
  parameter int unsigned N    = N_DEF,
  parameter int unsigned NREQ = NREQ_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         clr,
  output logic [NREQ-1:0]         ack,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic [NREQ*N-1:0]       count,
  output logic [NREQ-1:0]         wrap
);

  localparam int unsigned IW = $clog2(NREQ);

  logic [N-1:0]    cnt_q [NREQ];
  logic [N-1:0]    cnt_d [NREQ];
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] wrap_q, wrap_d;
  logic [IW-1:0]   gnt_id_q, gnt_id_d;
  logic [IW-1:0]   ptr_q, ptr_d;

  logic [NREQ-1:0] elig;
  logic            sel_valid;
  logic [IW-1:0]   sel_idx;
  logic [N-1:0]    cur;
  logic [N-1:0]    inc;
  logic            all_ones;

  assign elig = req & ~ack_q;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .elig      (elig),
    .ptr       (ptr_q),
    .sel_valid (sel_valid),
    .sel_idx   (sel_idx)
  );

  assign cur      = cnt_q[sel_idx];
  assign inc      = cur + N'(1);
  assign all_ones = &cur;

  always_comb begin
    cnt_d    = cnt_q;
    ack_d    = '0;
    wrap_d   = '0;
    gnt_id_d = gnt_id_q;
    ptr_d    = ptr_q;
    if (sel_valid) begin
      ack_d    = NREQ'(onehot(32'(sel_idx)));
      gnt_id_d = sel_idx;
      ptr_d    = (sel_idx == IW'(NREQ - 1)) ? '0 : sel_idx + IW'(1);
`ifdef COUNTER_SHARE_SATURATE_EN
      cnt_d[sel_idx] = all_ones ? cur : inc;
`else
      cnt_d[sel_idx] = inc;
`endif
      if (all_ones) wrap_d = ack_d;
    end
    // Clear wins over a same-cycle increment; the ack still stands but wrap is suppressed.
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (clr[i]) begin
        cnt_d[i]  = '0;
        wrap_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREQ; i++) cnt_q[i] <= '0;
      ack_q    <= '0;
      wrap_q   <= '0;
      gnt_id_q <= '0;
      ptr_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      wrap_q   <= wrap_d;
      gnt_id_q <= gnt_id_d;
      ptr_q    <= ptr_d;
    end
  end

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < NREQ; i++) count[i*N +: N] = cnt_q[i];
  end

  assign ack    = ack_q;
  assign wrap   = wrap_q;
  assign gnt_id = gnt_id_q;

endmodule

// File: tb/tb_counter_share_arbiter.sv
// Scoreboard bench for counter_share_arbiter with N=8, NREQ=4.
module tb_counter_share_arbiter;

  localparam int NB = 8;
  localparam int NR = 4;

  logic          clk;
  logic          reset;
  logic [NR-1:0] req;
  logic [NR-1:0] clr;
  logic [NR-1:0] ack;
  logic [1:0]    gnt_id;
  logic [NR*NB-1:0] count;
  logic [NR-1:0] wrap;

  counter_share_arbiter #(.N(NB), .NREQ(NR)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .clr    (clr),
    .ack    (ack),
    .gnt_id (gnt_id),
    .count  (count),
    .wrap   (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0]    ack;
    logic [1:0]       gnt;
    logic [NR-1:0]    wrap;
    logic [NR*NB-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  int tests_run = 0;
  int tests_failed = 0;

  logic [NB-1:0] m_cnt [NR];
  logic [NR-1:0] m_ack;
  logic [1:0]    m_gnt;
  int            m_ptr;
  int            ack_seen [NR];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < NR; ch++) begin
      m_cnt[ch]    = '0;
      ack_seen[ch] = 0;
    end
    m_ack = '0;
    m_gnt = '0;
    m_ptr = 0;
  endtask

  // Reference: predict the registered outputs after the coming edge.
  task automatic model_push(input logic [NR-1:0] r, input logic [NR-1:0] c);
    exp_t e;
    int sel;
    logic [NR-1:0] nack;
    sel  = -1;
    nack = '0;
    e.wrap = '0;
    for (int off = 0; off < NR; off++) begin
      int ch;
      ch = (m_ptr + off) % NR;
      if (sel < 0 && r[ch] && !m_ack[ch]) sel = ch;
    end
    if (sel >= 0) begin
      nack[sel] = 1'b1;
      m_gnt = 2'(sel);
      m_ptr = (sel + 1) % NR;
      if (m_cnt[sel] == 8'hFF) begin
`ifndef COUNTER_SHARE_SATURATE_EN
        m_cnt[sel] = 8'h00;
`endif
        e.wrap[sel] = 1'b1;
      end else begin
        m_cnt[sel] = m_cnt[sel] + 8'd1;
      end
    end
    for (int ch = 0; ch < NR; ch++) begin
      if (c[ch]) begin
        m_cnt[ch]   = '0;
        e.wrap[ch]  = 1'b0;
      end
    end
    m_ack = nack;
    e.ack = nack;
    e.gnt = m_gnt;
    e.cnt = '0;
    for (int ch = 0; ch < NR; ch++) e.cnt[ch*NB +: NB] = m_cnt[ch];
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [NR-1:0] r, input logic [NR-1:0] c);
    exp_t e;
    req = r;
    clr = c;
    model_push(r, c);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("ack", 64'(ack), 64'(e.ack));
    if (e.ack != '0) check("gnt_id", 64'(gnt_id), 64'(e.gnt));
    check("wrap", 64'(wrap), 64'(e.wrap));
    check("count", 64'(count), 64'(e.cnt));
    for (int ch = 0; ch < NR; ch++) if (ack[ch]) ack_seen[ch]++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    req   = '0;
    clr   = '0;
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_ack", 64'(ack), 64'd0);
    check("reset_gnt", 64'(gnt_id), 64'd0);
    check("reset_wrap", 64'(wrap), 64'd0);
    check("reset_count", 64'(count), 64'd0);
    reset = 1'b0;

    // Uncontended single request on channel 2
    step(4'b0100, 4'b0000);
    check("unc_ack", 64'(ack), 64'h4);
    check("unc_cnt2", 64'(count[2*NB +: NB]), 64'd1);
    step(4'b0000, 4'b0000);

    // Idle pointer hold: grant 3, idle, then 0011 must go to channel 0
    step(4'b1000, 4'b0000);
    check("idle_g3", 64'(gnt_id), 64'd3);
    for (int k = 0; k < 5; k++) step(4'b0000, 4'b0000);
    step(4'b0011, 4'b0000);
    check("idle_next", 64'(ack), 64'h1);
    step(4'b0000, 4'b0000);

    // Full contention from a fresh reset
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step(4'b1111, 4'b0000);
      if (k < 4) check("fc_order", 64'(gnt_id), 64'(k));
    end
    for (int ch = 0; ch < NR; ch++) begin
      check("fc_fair", 64'(ack_seen[ch]), 64'd2);
      check("fc_cnt_eq_acks", 64'(count[ch*NB +: NB]), 64'(ack_seen[ch]));
    end
    step(4'b0000, 4'b0000);

    // Clear collision: count[0]=5, then req[0] and clr[0] together
    do_reset();
    for (int k = 0; k < 10; k++) step(4'b0001, 4'b0000);
    check("clr_pre", 64'(count[NB-1:0]), 64'd5);
    step(4'b0001, 4'b0001);
    check("clr_cnt", 64'(count[NB-1:0]), 64'd0);
    check("clr_ack", 64'(ack[0]), 64'd1);
    check("clr_wrap", 64'(wrap[0]), 64'd0);
    step(4'b0000, 4'b0000);

    // Wrap on channel 1 after 255 increments
    step(4'b0000, 4'b0010);
    for (int k = 0; k < 510; k++) step(4'b0010, 4'b0000);
    check("wrap_pre", 64'(count[NB +: NB]), 64'd255);
    step(4'b0010, 4'b0000);
    check("wrap_ack", 64'(ack), 64'h2);
    check("wrap_pulse", 64'(wrap), 64'h2);
`ifdef COUNTER_SHARE_SATURATE_EN
    check("wrap_cnt", 64'(count[NB +: NB]), 64'd255);
`else
    check("wrap_cnt", 64'(count[NB +: NB]), 64'd0);
`endif
    step(4'b0000, 4'b0000);
    check("wrap_clear", 64'(wrap), 64'd0);

    // Async reset between edges while req=1010
    step(4'b1010, 4'b0000);
    step(4'b1010, 4'b0000);
    step(4'b1010, 4'b0000);
    #2;
    reset = 1'b1;
    #1;
    check("ares_ack", 64'(ack), 64'd0);
    check("ares_wrap", 64'(wrap), 64'd0);
    check("ares_gnt", 64'(gnt_id), 64'd0);
    check("ares_count", 64'(count), 64'd0);
    #2;
    reset = 1'b0;
    model_reset();
    step(4'b1010, 4'b0000);
    check("ares_first", 64'(ack), 64'h2);
    check("ares_first_id", 64'(gnt_id), 64'd1);
    step(4'b0000, 4'b0000);

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/counter_share_arbiter.md
# counter_share_arbiter

Round-robin arbiter that shares one N-bit incrementer among NREQ independent up-counter channels. Each channel's count is held in a register bank inside the block. Requesters raise `req[i]` to have their channel incremented, and the block grants one channel per cycle and acknowledges it. It sits between the clock0 counter cluster's consumers and a single increment datapath, replacing per-channel adders with one shared adder.

## Interface
Parameters:
- `N`, 36: width of each channel counter.
- `NREQ`, 4: number of requesters/channels; must be at least 2.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  NREQ  increment request per channel; level, held until acked.
- `clr`  in  NREQ  synchronous clear per channel.
- `ack`  out  NREQ  one-hot, one-cycle acknowledge of a serviced increment.
- `gnt_id`  out  clog2(NREQ)  index of the channel acked; valid only while `|ack`.
- `count`  out  NREQ*N  concatenated counters; channel i is at `[i*N +: N]`.
- `wrap`  out  NREQ  one-cycle terminal-event pulse per channel.

## Operation
- **Reset values.** Reset asserted (asynchronously) sets:
  - all `count` to 0;
  - `ack` to 0, `wrap` to 0, `gnt_id` to 0;
  - round-robin pointer `ptr` to 0.
- **Eligibility.** A channel is eligible when `req[i]=1` and `ack[i]=0`. A channel is masked during its own ack cycle.
- **Selection.** Each cycle, the first eligible channel searching `ptr, ptr+1, …, NREQ-1, 0, …` (mod NREQ) is selected. At most one channel is selected per cycle.
- **Update on selection of channel g, at the edge:**
  - `count[g] <= count[g]+1` (mod 2^N);
  - `ack <= onehot(g)`, `gnt_id <= g`;
  - `ptr <= (g+1) mod NREQ`.
- **No eligible channel.** `ack <= 0`, and `ptr` is unchanged.
- **Wrap-around.** If `count[g]` is all-ones when incremented, it becomes 0 and `wrap[g]` pulses in the same cycle as `ack[g]`.
- **Clear.** `clr[i]` forces `count[i] <= 0` at the edge.
  - Clear has priority over a simultaneous increment of the same channel. The request is still consumed: ack is issued, `ptr` advances, and `wrap` stays 0.
  - Clear of a non-granted channel does not affect arbitration.
- **Requester rule.** Deassert `req[i]` before the edge that ends the `ack[i]` cycle if no further increment is wanted. A requester holding `req` continuously gets at most one increment every 2 cycles.
- **Reset mid-operation.** A pending request is lost. No ack is issued for it after reset releases, unless `req` is still high, in which case it is arbitrated anew with `ptr=0`.

## Timing
- Request-to-ack latency is 1 cycle when uncontended: `req` high at edge k means `ack` is high after edge k, and `count` is updated at that same edge.
- Worst-case wait under full contention is NREQ cycles.
- `ack`, `gnt_id`, `wrap` and `count` are all registered outputs. There are no combinational paths from inputs to outputs.
- Throughput is one increment per cycle aggregate.

## Configuration
- `COUNTER_SHARE_SATURATE_EN` defined:
  - an increment of an all-ones count leaves it at all-ones (saturates);
  - `wrap[g]` pulses on every such saturated increment;
  - the ack is still issued.
- `COUNTER_SHARE_SATURATE_EN` undefined: modulo-2^N wrap to 0 as described above.

## Structure
- Package `counter_share_pkg` holds:
  - default `N`/`NREQ` constants;
  - the index-width constant;
  - a `onehot` helper function.
- Sub-module `rr_arbiter` (parameter NREQ):
  - inputs: eligible vector, `ptr`;
  - outputs: `sel_valid`, `sel_idx`;
  - purely combinational.
- `counter_share_arbiter` owns:
  - the counter bank;
  - the shared incrementer and mux;
  - the `ptr` register;
  - the output registers.

## Test plan
- **Uncontended:** after reset, `req[2]` held 1 cycle → `ack=4'b0100`, `gnt_id=2`, `count[2]=1`, `ptr=3`.
- **Full contention:** all `req` held high for 8 cycles → acks in order 0,1,2,3 on cycles 1–4, and each ack cycle masks its own channel. Check that the grant sequence is fair and each count equals its number of acks.
- **Wrap:** preload by clearing, then run channel 1 to 2^N-1 (with N overridden to 8: 255 increments), then one more `req[1]` → `count[1]=0` and `wrap[1]` pulses with `ack[1]`.
  - With `COUNTER_SHARE_SATURATE_EN`: count stays 255 and `wrap[1]` pulses.
- **Clear collision:** `count[0]=5`, then `req[0]` and `clr[0]` in the same cycle → `count[0]=0`, `ack[0]=1`, `wrap[0]=0`.
- **Async reset mid-stream:** `reset` pulsed between clock edges while `req=4'b1010` → all outputs 0 immediately. With `req` still 1010 after release, the first ack goes to channel 1.
- **Idle pointer hold:** grant channel 3, then no requests for 5 cycles, then `req=4'b0011` → the next ack is channel 0 (`ptr` wrapped to 0 after the channel-3 grant and was held while idle).
